// File: rtl/tea_byte_packer.sv
// rtl/tea_byte_packer.sv - packs ciphertext bytes into 64-bit blocks and tracks decryptor latency
module tea_byte_packer #(
    parameter int         LAT = 33,
    parameter logic [7:0] PAD = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [63:0] blk,
    output logic        dec_ena,
    output logic        out_valid,
    output logic        out_last,
    input  logic        out_ready,
    output logic [15:0] blk_cnt
);

    logic [2:0]  idx;
    logic [63:0] asm_q;
    logic [63:0] blk_next;
    logic [1:0]  tag [LAT];
    logic        accept;
    logic        issue;

    assign out_valid = tag[LAT-1][1];
    assign out_last  = tag[LAT-1][0];

    // The whole packer and the decryptor freeze together while a result waits downstream.
    assign dec_ena  = ~(out_valid & ~out_ready);
    assign in_ready = dec_ena;
    assign accept   = in_valid & dec_ena;
    assign issue    = accept & (in_last | (idx == 3'd7));

    always_comb begin
        blk_next = '0;
        for (int k = 0; k < 8; k++) begin
            if (3'(k) < idx)
                blk_next[63-8*k -: 8] = asm_q[63-8*k -: 8];
            else if (3'(k) == idx)
                blk_next[63-8*k -: 8] = in_byte;
            else
                blk_next[63-8*k -: 8] = PAD;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx     <= '0;
            asm_q   <= '0;
            blk     <= '0;
            blk_cnt <= '0;
        end else if (accept) begin
            asm_q[63-8*idx -: 8] <= in_byte;
            if (issue) begin
                idx     <= '0;
                blk     <= blk_next;
                blk_cnt <= blk_cnt + 16'd1;
            end else begin
                idx <= idx + 3'd1;
            end
        end
    end

    // Tag chain mirrors the decryptor pipeline; bubbles enter when no block is issued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LAT; i++)
                tag[i] <= '0;
        end else if (dec_ena) begin
            tag[0] <= {issue, issue & in_last};
            for (int i = 1; i < LAT; i++)
                tag[i] <= tag[i-1];
        end
    end

endmodule

// File: tb/tb_tea_byte_packer.sv
// tb/tb_tea_byte_packer.sv - self-checking bench for tea_byte_packer
module tb_tea_byte_packer;
    localparam int         LAT = 33;
    localparam logic [7:0] PAD = 8'h00;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  in_byte = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [63:0] blk;
    logic        dec_ena;
    logic        out_valid;
    logic        out_last;
    logic        out_ready = 1'b1;
    logic [15:0] blk_cnt;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    tea_byte_packer #(.LAT(LAT), .PAD(PAD)) dut (
        .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .blk(blk), .dec_ena(dec_ena),
        .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
        .blk_cnt(blk_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Model: bytes collected per block, each issued block counts down LAT-1 enabled cycles.
    typedef struct { int rem; logic last; } ent_t;
    logic [7:0]  m_bytes [$];
    ent_t        m_ents [$];
    logic [63:0] m_blk = '0;
    logic [15:0] m_cnt = '0;
    bit          m_en;

    function automatic bit m_ov();
        return (m_ents.size() > 0) && (m_ents[0].rem == 0);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_bytes.delete();
            m_ents.delete();
            m_blk = '0;
            m_cnt = '0;
        end else begin
            m_en = !(m_ov() && !out_ready);
            if (m_en) begin
                foreach (m_ents[i]) m_ents[i].rem--;
                if (m_ents.size() > 0 && m_ents[0].rem < 0) void'(m_ents.pop_front());
                if (in_valid) begin
                    m_bytes.push_back(in_byte);
                    if (in_last || m_bytes.size() == 8) begin
                        m_blk = {8{PAD}};
                        foreach (m_bytes[i]) m_blk[63-8*i -: 8] = m_bytes[i];
                        m_bytes.delete();
                        m_cnt = m_cnt + 16'd1;
                        m_ents.push_back('{LAT-1, in_last});
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        logic eov, elast;
        eov   = m_ov();
        elast = eov ? m_ents[0].last : 1'b0;
        check("out_valid", 64'(out_valid), 64'(eov));
        check("out_last", 64'(out_last), 64'(elast));
        check("dec_ena", 64'(dec_ena), 64'(!(eov && !out_ready)));
        check("in_ready", 64'(in_ready), 64'(!(eov && !out_ready)));
        check("blk", blk, m_blk);
        check("blk_cnt", 64'(blk_cnt), 64'(m_cnt));
    end

    task automatic send_byte(input logic [7:0] b, input logic l);
        int  n = 0;
        logic acc = 1'b0;
        in_valid = 1'b1;
        in_byte  = b;
        in_last  = l;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("send_accept", 64'(acc), 64'd1);
    endtask

    initial begin
        int t, stalls, phase, nov, off;
        int offs [$];

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_blk", blk, 64'd0);
        check("rst_blk_cnt", 64'(blk_cnt), 64'd0);
        check("rst_dec_ena", 64'(dec_ena), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Basic block
        for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b0);
        t = cyc - 1;
        @(negedge clk);
        check("basic_blk", blk, 64'h0102030405060708);
        check("basic_cnt", 64'(blk_cnt), 64'd1);
        while (!out_valid && cyc < t + 100) @(negedge clk);
        check("basic_latency", 64'(cyc - t), 64'd33);
        check("basic_last", 64'(out_last), 64'd0);
        @(posedge clk); #1;

        // Short final block followed by a one-byte block, then a 5-cycle stall
        out_ready = 1'b0;
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b1);
        @(negedge clk);
        check("short_blk", blk, 64'hAABBCC0000000000);
        @(posedge clk); #1;
        send_byte(8'h55, 1'b1);
        t = cyc - 1;
        stalls = 0;
        phase = 0;
        while (phase < 3 && cyc < t + 100) begin
            @(negedge clk);
            if (phase == 0 && out_valid) begin
                stalls++;
                check("stall_dec_ena", 64'(dec_ena), 64'd0);
                check("stall_in_ready", 64'(in_ready), 64'd0);
                if (stalls == 1) begin
                    check("short_last", 64'(out_last), 64'd1);
                    in_valid = 1'b1;
                    in_byte  = 8'h77;
                    in_last  = 1'b1;
                end
                if (stalls == 5) begin
                    @(posedge clk); #1;
                    out_ready = 1'b1;
                    in_valid  = 1'b0;
                    in_last   = 1'b0;
                    phase = 1;
                end
            end else if (phase == 1) begin
                phase = 2;
            end else if (phase == 2 && out_valid) begin
                check("stall_latency", 64'(cyc - t), 64'd38);
                phase = 3;
            end
        end
        check("stall_done", 64'(phase), 64'd3);
        check("stall_cnt", 64'(blk_cnt), 64'd3);
        @(posedge clk); #1;

        // Back-to-back blocks
        for (int i = 0; i < 24; i++) begin
            send_byte(8'(8'h10 + i), 1'b0);
            if (i == 7) t = cyc - 1;
        end
        while (cyc < t + 60) begin
            @(negedge clk);
            if (out_valid) offs.push_back(cyc - t);
        end
        check("b2b_count", 64'(offs.size()), 64'd3);
        for (int i = 0; i < offs.size() && i < 3; i++)
            check("b2b_offset", 64'(offs[i]), 64'(33 + 8 * i));
        check("b2b_cnt", 64'(blk_cnt), 64'd6);
        @(posedge clk); #1;

        // Reset with one block in flight and a partial block assembled
        for (int i = 0; i < 8; i++) send_byte(8'(8'hE0 + i), 1'b0);
        for (int i = 0; i < 4; i++) send_byte(8'(8'hD0 + i), 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_blk", blk, 64'd0);
        check("midrst_cnt", 64'(blk_cnt), 64'd0);
        check("midrst_dec_ena", 64'(dec_ena), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 8; i++) send_byte(8'(8'hF0 + i), 1'b0);
        t = cyc - 1;
        @(negedge clk);
        check("midrst_new_blk", blk, 64'hF0F1F2F3F4F5F6F7);
        nov = 0;
        off = 0;
        while (cyc < t + 60) begin
            if (out_valid) begin
                nov++;
                off = cyc - t;
            end
            @(negedge clk);
        end
        check("midrst_ov_count", 64'(nov), 64'd1);
        check("midrst_ov_offset", 64'(off), 64'd33);
        @(posedge clk); #1;

        // Counter wrap: one-byte blocks every cycle
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_byte  = 8'h5A;
        repeat (65534) @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        check("wrap_pre", 64'(blk_cnt), 64'hFFFF);
        @(posedge clk); #1;
        send_byte(8'hC3, 1'b1);
        @(negedge clk);
        check("wrap_post", 64'(blk_cnt), 64'h0000);
        check("wrap_blk", blk, 64'hC300000000000000);
        repeat (40) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tea_byte_packer.md
TEA_BYTE_PACKER -- requirements
Module: tea_byte_packer

Interface
REQ-001 Parameter LAT, default 33: decryptor latency in clocks, from block issue to a valid decryptor output.
REQ-002 Parameter PAD, default 8'h00: byte used to fill a short final block.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; clears all state immediately on assertion.
REQ-005 in_byte  input  8  ciphertext byte from upstream.
REQ-006 in_valid  input  1  in_byte is valid this cycle.
REQ-007 in_last  input  1  qualifies in_byte as the final byte of a message.
REQ-008 in_ready  output  1  packer accepts a byte this cycle.
REQ-009 blk  output  64  registered block; connects to the decryptor inBlock64.
REQ-010 dec_ena  output  1  global enable; connects to the decryptor ena.
REQ-011 out_valid  output  1  decryptor outBlock64 is valid this cycle.
REQ-012 out_last  output  1  qualifies out_valid; the block closed a message.
REQ-013 out_ready  input  1  downstream consumes outBlock64 this cycle.
REQ-014 blk_cnt  output  16  count of blocks issued, modulo 2^16.

Function
REQ-015 A byte is accepted when in_valid and in_ready are both 1; in_ready SHALL equal dec_ena.
REQ-016 dec_ena SHALL be combinational: 0 when out_valid=1 and out_ready=0; 1 otherwise.
REQ-017 While dec_ena=0, all packer state SHALL hold: byte index, assembly register, blk, tag chain and blk_cnt.
REQ-018 Byte index idx (3 bits) SHALL select the lane: byte k of a block lands in bits [63-8k:56-8k], so the first byte is at the MSB.
REQ-019 When a byte is accepted with idx<7 and in_last=0, the packer SHALL store the byte and increment idx.
REQ-020 When a byte is accepted with idx=7, or with in_last=1, the packer SHALL issue a block:
- blk loads the assembled bytes plus the current byte.
- Lanes above idx are filled with PAD.
- idx returns to 0.
- The issue tag is set for exactly one enabled cycle.
- blk_cnt increments.
REQ-021 A block is issued at most once per enabled cycle; blk SHALL hold its value between issues.
REQ-022 When no block is issued in an enabled cycle, a zero tag (bubble) SHALL enter the tag chain; blk is unchanged.
REQ-023 The tag chain SHALL be LAT stages of {valid, last}, shifting only when dec_ena=1; out_valid and out_last are the final stage.
REQ-024 Latency: a block issued in cycle t, with no stalls, SHALL produce out_valid=1 in cycle t+LAT.
REQ-025 Each stall cycle (dec_ena=0) SHALL add exactly one cycle to this latency.
REQ-026 The packer SHALL NOT issue a block with in_last=0 and idx<7.
REQ-027 in_last=1 at idx=0 SHALL issue a block with the byte in [63:56] and PAD in all other lanes.
REQ-028 blk_cnt SHALL wrap from 16'hFFFF to 16'h0000 without any other effect.
REQ-029 out_valid SHALL remain asserted with the same outBlock64 until out_ready=1; the pipeline is frozen meanwhile.

Reset
REQ-030 On rst=0, the following SHALL clear asynchronously:
- blk=64'h0, idx=0, blk_cnt=0.
- All tag stages=0, so out_valid=0 and out_last=0.
REQ-031 During reset dec_ena=1 and in_ready=1; no byte is accepted while rst=0.
REQ-032 Reset mid-message or mid-pipeline SHALL discard all partial bytes and in-flight tags; no out_valid follows until a new block is issued.
REQ-033 After rst deasserts, the first byte accepted SHALL be byte 0 of a new block.

Verification
REQ-034 Basic block: bytes 01..08 on 8 consecutive cycles, out_ready=1 -> blk=64'h0102030405060708 one cycle after the 8th byte; out_valid=1, out_last=0 exactly 33 cycles after issue; blk_cnt=1.
REQ-035 Short final block: bytes AA,BB,CC with in_last on CC -> blk=64'hAABBCC0000000000; out_last=1 with out_valid.
REQ-036 Stall: out_ready=0 for 5 cycles while out_valid=1 ->
- dec_ena=0 and in_ready=0 for those 5 cycles.
- Offered bytes are not consumed.
- The next block's out_valid arrives 5 cycles later than unstalled.
REQ-037 Back-to-back: 3 blocks (24 bytes, no gaps) -> out_valid high for 1 cycle at each of t+33, t+41 and t+49; bubbles between them are low.
REQ-038 Reset mid-flight: rst=0 for 1 cycle after byte 4 of a block, then a full new block ->
- blk=0 and blk_cnt=0 immediately.
- Only one out_valid appears, for the new block.
REQ-039 Wrap: preload 65535 blocks (or force blk_cnt=16'hFFFF), issue one block -> blk_cnt=16'h0000.
